// File: rtl/led_pattern_driver.sv
// LED pattern driver: per-channel OFF/ON/REPEAT/BURST blinkers
// sharing one prescaled tick and a global output enable.
module led_pattern_driver #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int BURST_W  = 8,
  parameter int PRESCALE = 1,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_cfg_valid,
  input  logic [CH_W-1:0]    i_cfg_ch,
  input  logic [1:0]         i_cfg_mode,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [CNT_W-1:0]   i_cfg_on,
  input  logic [BURST_W-1:0] i_cfg_count,
  output logic [N_CH-1:0]    o_led_drive,
  output logic [N_CH-1:0]    o_active,
  output logic [N_CH-1:0]    o_done
);

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BURST = 2'b11;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  always_comb begin
    tick = (ps_q == PS_LAST);
    ps_d = tick ? '0 : ps_q + PS_W'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) ps_q <= '0;
    else         ps_q <= ps_d;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   on_q, on_d;
    logic [CNT_W-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0]   last;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               done_q, done_d;
    logic               wr, run, pat, led;

    assign wr   = i_cfg_valid && (i_cfg_ch == CH_W'(c));
    assign run  = mode_q[1];
    // P=0 is treated as a one-tick period
    assign last = (per_q == '0) ? '0 : per_q - CNT_W'(1);
    assign pat  = (ph_q < on_q);

    always_comb begin
      mode_d = mode_q;
      per_d  = per_q;
      on_d   = on_q;
      ph_d   = ph_q;
      rem_d  = rem_q;
      done_d = 1'b0;
      if (wr) begin
        mode_d = i_cfg_mode;
        per_d  = i_cfg_period;
        on_d   = i_cfg_on;
        ph_d   = '0;
        rem_d  = i_cfg_count;
        if (i_cfg_mode == M_BURST && i_cfg_count == '0) begin
          mode_d = M_OFF;
          done_d = 1'b1;
        end
      end else if (run && tick) begin
        if (ph_q == last) begin
          ph_d = '0;
          if (mode_q == M_BURST) begin
            if (rem_q <= BURST_W'(1)) begin
              mode_d = M_OFF;
              done_d = 1'b1;
            end else begin
              rem_d = rem_q - BURST_W'(1);
            end
          end
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        mode_q <= M_OFF;
        per_q  <= '0;
        on_q   <= '0;
        ph_q   <= '0;
        rem_q  <= '0;
        done_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        per_q  <= per_d;
        on_q   <= on_d;
        ph_q   <= ph_d;
        rem_q  <= rem_d;
        done_q <= done_d;
      end
    end

    always_comb begin
      led = 1'b0;
      unique case (1'b1)
        (mode_q == M_ON): led = i_enable;
        run:              led = pat & i_enable;
        default:          led = 1'b0;
      endcase
    end

    assign o_led_drive[c] = led;
    assign o_active[c]    = (mode_q != M_OFF);
    assign o_done[c]      = done_q;
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Testbench for led_pattern_driver: directed scenarios plus random
// traffic against an elapsed-tick reference model, at PRESCALE 1 and 3.
module tb_led_pattern_driver;

  localparam int N = 5;
  localparam int CW = 16;
  localparam int BW = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic          cfg_valid;
  logic [2:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_on;
  logic [BW-1:0] cfg_count;
  logic [N-1:0]  led1, act1, done1;
  logic [N-1:0]  led3, act3, done3;

  int n_chk = 0;
  int n_fail = 0;

  int psv[2] = '{1, 3};
  int m_cyc[2];
  int m_mode[2][N];
  int m_p[2][N];
  int m_h[2][N];
  int m_k[2][N];
  int m_t[2][N];
  bit m_done[2][N];

  led_pattern_driver #(
    .N_CH(N), .CNT_W(CW), .BURST_W(BW), .PRESCALE(1)
  ) dut1 (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_cfg_valid(cfg_valid), .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode), .i_cfg_period(cfg_period),
    .i_cfg_on(cfg_on), .i_cfg_count(cfg_count),
    .o_led_drive(led1), .o_active(act1), .o_done(done1)
  );

  led_pattern_driver #(
    .N_CH(N), .CNT_W(CW), .BURST_W(BW), .PRESCALE(3)
  ) dut3 (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_cfg_valid(cfg_valid), .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode), .i_cfg_period(cfg_period),
    .i_cfg_on(cfg_on), .i_cfg_count(cfg_count),
    .o_led_drive(led3), .o_active(act3), .o_done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model keeps ticks elapsed since the write; phase and burst end
  // follow from division by the effective period.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit tk;
      if (rst) begin
        m_cyc[d] = 0;
        for (int c = 0; c < N; c++) begin
          m_mode[d][c] = 0;
          m_t[d][c] = 0;
          m_done[d][c] = 0;
        end
      end else begin
        tk = (m_cyc[d] % psv[d]) == psv[d] - 1;
        m_cyc[d]++;
        for (int c = 0; c < N; c++) begin
          int pe;
          pe = (m_p[d][c] == 0) ? 1 : m_p[d][c];
          m_done[d][c] = 0;
          if (cfg_valid && int'(cfg_ch) == c) begin
            m_mode[d][c] = int'(cfg_mode);
            m_p[d][c] = int'(cfg_period);
            m_h[d][c] = int'(cfg_on);
            m_k[d][c] = int'(cfg_count);
            m_t[d][c] = 0;
            if (cfg_mode == 2'b11 && cfg_count == 0) begin
              m_mode[d][c] = 0;
              m_done[d][c] = 1;
            end
          end else if (m_mode[d][c] >= 2 && tk) begin
            m_t[d][c]++;
            if (m_mode[d][c] == 3 && m_t[d][c] == m_k[d][c] * pe) begin
              m_mode[d][c] = 0;
              m_t[d][c] = 0;
              m_done[d][c] = 1;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] exp_led(int d);
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) begin
      int pe;
      pe = (m_p[d][c] == 0) ? 1 : m_p[d][c];
      case (m_mode[d][c])
        0:       v[c] = 1'b0;
        1:       v[c] = en;
        default: v[c] = ((m_t[d][c] % pe) < m_h[d][c]) && en;
      endcase
    end
    return v;
  endfunction

  function automatic logic [N-1:0] exp_act(int d);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (m_mode[d][c] != 0);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_done(int d);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_done[d][c];
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("led_ps1", led1, exp_led(0));
    chk("act_ps1", act1, exp_act(0));
    chk("done_ps1", done1, exp_done(0));
    chk("led_ps3", led3, exp_led(1));
    chk("act_ps3", act3, exp_act(1));
    chk("done_ps3", done3, exp_done(1));
  endtask

  task automatic wr(int ch, int mode, int p, int h, int k);
    cfg_valid = 1'b1;
    cfg_ch = 3'(ch);
    cfg_mode = 2'(mode);
    cfg_period = CW'(p);
    cfg_on = CW'(h);
    cfg_count = BW'(k);
    cycle();
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [0:6] bexp;
    int highs;
    bexp = 7'b1101100;
    rst = 1'b1;
    en = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_mode = '0;
    cfg_period = '0;
    cfg_on = '0;
    cfg_count = '0;
    for (int i = 0; i < 2; i++) cycle();
    rst = 1'b0;
    cycle();

    // reset mid-pattern
    wr(0, 2, 4, 2, 0);
    wr(3, 1, 0, 0, 0);
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_led", 32'(led1), 32'd0);
    chk("rst_act", 32'(act1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("post_rst_led", 32'(led1 | led3), 32'd0);

    // repeat with enable gating
    wr(0, 2, 4, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycle();
      chk("repeat_led", 32'(led1[0]), 32'(i % 4 == 0));
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("gate_led", 32'(led1[0]), 32'd0);
    end
    en = 1'b1;
    cycle();
    cycle();
    chk("repeat_cont", 32'(led1[0]), 32'd1);

    // burst
    wr(1, 3, 3, 2, 2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cycle();
      chk("burst_led", 32'(led1[1]), 32'(bexp[i]));
      chk("burst_done", 32'(done1[1]), 32'(i == 6));
      chk("burst_act", 32'(act1[1]), 32'(i != 6));
    end
    cycle();
    chk("burst_done_end", 32'(done1[1]), 32'd0);

    // edge values
    wr(2, 2, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("h0_led", 32'(led1[2]), 32'd0);
      cycle();
    end
    wr(2, 2, 3, 5, 0);
    for (int i = 0; i < 4; i++) begin
      chk("hbig_led", 32'(led1[2]), 32'd1);
      cycle();
    end
    wr(2, 2, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("p0_led", 32'(led1[2]), 32'd1);
      cycle();
    end
    wr(3, 3, 5, 1, 0);
    chk("k0_done", 32'(done1[3]), 32'd1);
    chk("k0_act", 32'(act1[3]), 32'd0);
    cycle();
    chk("k0_done_end", 32'(done1[3]), 32'd0);

    // abort mid-burst
    wr(1, 3, 3, 2, 3);
    for (int i = 0; i < 3; i++) cycle();
    wr(1, 2, 4, 2, 0);
    chk("abort_done", 32'(done1[1]), 32'd0);
    chk("abort_led", 32'(led1[1]), 32'd1);
    for (int i = 0; i < 6; i++) cycle();

    // write on the final period-end edge
    wr(1, 3, 2, 1, 1);
    cycle();
    wr(1, 2, 3, 1, 0);
    chk("coll_done", 32'(done1[1]), 32'd0);
    chk("coll_act", 32'(act1[1]), 32'd1);
    chk("coll_led", 32'(led1[1]), 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // prescale 3 and out-of-range channel
    wr(2, 2, 2, 1, 0);
    for (int i = 0; i < 6; i++) cycle();
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      highs += int'(led3[2]);
    end
    chk("ps3_duty", 32'(highs), 32'd6);
    wr(N, 1, 1, 1, 1);
    wr(7, 3, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 100) == 0;
      en = ($urandom % 8) != 0;
      cfg_valid = ($urandom % 4) == 0;
      cfg_ch = 3'($urandom % 8);
      cfg_mode = 2'($urandom % 4);
      cfg_period = CW'($urandom % 6);
      cfg_on = CW'($urandom % 7);
      cfg_count = BW'($urandom % 4);
      cycle();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
Multi-channel successor to the single-output LED blinker. Each channel runs its own period, on-time and pulse count, in one of four modes: off, on, repeat, burst. A host or sequencer programs channels through a simple always-ready config write port. A shared prescaler sets the time base, and a global enable gates all outputs, as on the earlier blinker.

Parameters:
N_CH, 4, number of LED channels (1..16)
CNT_W, 16, width of period/on-time fields in ticks
BURST_W, 8, width of burst pulse-count field
PRESCALE, 1, clocks per tick (>=1)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  global output gate; does not stop counters
i_cfg_valid  in  1  config write strobe; always accepted
i_cfg_ch  in  max(1,$clog2(N_CH))  target channel
i_cfg_mode  in  2  00 OFF, 01 ON, 10 REPEAT, 11 BURST
i_cfg_period  in  CNT_W  period P in ticks
i_cfg_on  in  CNT_W  on-time H in ticks
i_cfg_count  in  BURST_W  burst pulse count K
o_led_drive  out  N_CH  LED outputs
o_active  out  N_CH  channel mode != OFF
o_done  out  N_CH  one-cycle pulse when a burst completes

Behaviour:
- Clock and reset: single clock i_clock. i_reset is synchronous, active-high.
- Reset: all channels go to OFF, with phase=0 and remaining=0. The prescaler clears to 0. o_led_drive, o_active and o_done are all 0 from the first edge with i_reset high.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 when count==PRESCALE-1. With PRESCALE=1, tick is high every cycle. The prescaler is not reset by config writes.
- Config write: captured on the edge where i_cfg_valid=1.
  - Stores mode, P, H and K for channel i_cfg_ch.
  - Sets phase=0 and remaining=K.
  - Takes effect immediately after that edge: zero-cycle latency to o_led_drive.
  - i_cfg_ch >= N_CH: write ignored.
- Effective period: Pe = max(P,1), so P=0 behaves as P=1.
- Pattern output: pat = (phase < H). H=0 gives constant low; H>=Pe gives constant high.
- Output per mode (combinational from registers):
  - OFF: o_led_drive[c] = 0.
  - ON: o_led_drive[c] = i_enable.
  - REPEAT/BURST: o_led_drive[c] = pat & i_enable.
- Phase advance (REPEAT/BURST only, on tick):
  - If phase == Pe-1: phase becomes 0 and a period-end event occurs.
  - Otherwise: phase increments by 1.
  - In OFF/ON, phase holds at 0.
- Burst period-end:
  - If remaining <= 1: mode becomes OFF, phase=0, and o_done[c]=1 for exactly the next cycle.
  - Otherwise: remaining decrements by 1.
- BURST with K=0: on the write edge the channel enters OFF directly, and o_done[c] pulses for one cycle after that edge.
- i_enable: gates outputs only. Phase, remaining and burst completion proceed while i_enable=0.
- Simultaneous events:
  - A config write to channel c wins over c's own period-end in the same cycle. The new config loads and no o_done is raised (except the K=0 BURST case above).
  - A write aborts an in-progress burst with no done pulse.
  - Writes to other channels do not disturb channel c.
  - i_reset wins over everything; no o_done is raised on reset.
- Arithmetic: comparisons are unsigned. Phase is CNT_W bits and never exceeds Pe-1, so no wrap beyond period. Remaining is BURST_W bits and never underflows.
- Channels: fully independent.
- Expected size: about 150-250 lines of RTL with a generate-per-channel structure.

Test Plan:
1. Reset: assert i_reset 2 cycles mid-pattern. Required: o_led_drive=0, o_active=0, o_done=0 from the first reset edge. After release with no writes, outputs stay 0.
2. REPEAT (PRESCALE=1): ch0, P=4, H=1, i_enable=1. Required: o_led_drive[0] = 1,0,0,0 repeating, starting the cycle after the write. Dropping i_enable for 3 cycles forces 0, and on re-enable the phase is continuous (no restart).
3. BURST: ch1, P=3, H=2, K=2. Required: o_led_drive[1] = 1,1,0,1,1,0 then 0. o_done[1] is high for exactly one cycle (cycle 7 after the write) and o_active[1] falls together with it. ch0 is unaffected.
4. Edge values: H=0 gives constant 0. H=5 with P=3 gives constant 1. P=0, H=1 gives constant 1. BURST K=0 gives o_done pulse on cycle 1 and o_active=0.
5. Abort/collision: rewrite ch1 REPEAT mid-burst. Required: no o_done, and the pattern restarts at phase 0. Writing ch1 on the exact final period-end cycle also gives no o_done and loads the new config.
6. Prescale: PRESCALE=3, P=2, H=1, REPEAT. Required: output high 3 cycles, low 3 cycles, repeating. A write with i_cfg_ch=N_CH changes nothing.
